// File: rtl/memory_stage.sv
// Memory pipeline stage: issues loads/stores on a request/acknowledge bus,
// extends load data, and registers the result for writeback.

package constants;
    localparam logic [31:0] RESET_ADDRESS = 32'h8000_0000;
endpackage

package instruction;
    typedef enum logic [3:0] {OTHER, LB, LH, LW, LBU, LHU, SB, SH, SW} mem_op_t;
    typedef struct packed {
        logic [31:0] raw;
        logic [4:0]  rd_address;
        mem_op_t     mem_op;
    } t;
    localparam t NOP = '{raw: 32'h0000_0013, rd_address: 5'd0, mem_op: OTHER};
endpackage

package forwarding;
    typedef struct packed {
        logic [4:0]  rd_address;
        logic [31:0] rd_data;
        logic        data_valid;
    } t;
endpackage

package pipeline_status;
    typedef enum logic {VALID, BUBBLE} forwards_t;
    typedef enum logic [1:0] {READY, STALL, JUMP} backwards_t;
endpackage

module memory_stage (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 source_data_in,
    input  logic [31:0]                 rd_data_in,
    input  instruction::t               instruction_in,
    input  logic [31:0]                 program_counter_in,
    input  logic [31:0]                 next_program_counter_in,
    output logic [31:0]                 rd_data_reg_out,
    output instruction::t               instruction_reg_out,
    output logic [31:0]                 program_counter_reg_out,
    output logic [31:0]                 next_program_counter_reg_out,
    output logic                        misaligned_reg_out,
    output forwarding::t                forwarding_out,
    input  pipeline_status::forwards_t  status_forwards_in,
    output pipeline_status::forwards_t  status_forwards_out,
    input  pipeline_status::backwards_t status_backwards_in,
    output pipeline_status::backwards_t status_backwards_out,
    output logic                        mem_cyc_out,
    output logic                        mem_stb_out,
    output logic                        mem_we_out,
    output logic [31:0]                 mem_address_out,
    output logic [3:0]                  mem_sel_out,
    output logic [31:0]                 mem_write_data_out,
    input  logic [31:0]                 mem_read_data_in,
    input  logic                        mem_ack_in
);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, HOLD} state_t;

    state_t         state;
    instruction::t  pend_instr;
    logic [31:0]    pend_pc;
    logic [31:0]    pend_npc;
    logic [31:0]    pend_addr;
    logic [31:0]    hold_data;

    logic [1:0]     offset;
    logic           is_mem;
    logic           is_store;
    logic           misaligned;
    logic [3:0]     sel;
    logic [31:0]    wdata;
    logic [31:0]    shifted;
    logic [31:0]    load_result;
    logic           downstream_stall;
    logic           accept;

    assign offset           = rd_data_in[1:0];
    assign downstream_stall = (status_backwards_in == pipeline_status::STALL);
    assign accept           = (state == IDLE) &&
                              (status_forwards_in == pipeline_status::VALID) &&
                              !downstream_stall;

    assign status_backwards_out = ((state != IDLE) || downstream_stall) ?
                                  pipeline_status::STALL : pipeline_status::READY;

    assign forwarding_out = '{
        rd_address: instruction_reg_out.rd_address,
        rd_data:    rd_data_reg_out,
        data_valid: (status_forwards_out == pipeline_status::VALID) && !misaligned_reg_out
    };

    // Decode the incoming instruction into byte lanes, write data and alignment.
    always_comb begin
        is_mem     = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        sel        = '0;
        wdata      = '0;
        case (instruction_in.mem_op)
            instruction::LB, instruction::LBU: begin
                is_mem = 1'b1;
                sel    = 4'b0001 << offset;
            end
            instruction::LH, instruction::LHU: begin
                is_mem     = 1'b1;
                sel        = offset[1] ? 4'b1100 : 4'b0011;
                misaligned = offset[0];
            end
            instruction::LW: begin
                is_mem     = 1'b1;
                sel        = 4'b1111;
                misaligned = (offset != 2'b00);
            end
            instruction::SB: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
                sel      = 4'b0001 << offset;
                wdata    = {4{source_data_in[7:0]}};
            end
            instruction::SH: begin
                is_mem     = 1'b1;
                is_store   = 1'b1;
                sel        = offset[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{source_data_in[15:0]}};
                misaligned = offset[0];
            end
            instruction::SW: begin
                is_mem     = 1'b1;
                is_store   = 1'b1;
                sel        = 4'b1111;
                wdata      = source_data_in;
                misaligned = (offset != 2'b00);
            end
            default: ;
        endcase
    end

    // Extract and extend the returned data for the outstanding access.
    always_comb begin
        shifted = mem_read_data_in >> {pend_addr[1:0], 3'b000};
        case (pend_instr.mem_op)
            instruction::LB:  load_result = {{24{shifted[7]}}, shifted[7:0]};
            instruction::LBU: load_result = {24'd0, shifted[7:0]};
            instruction::LH:  load_result = {{16{shifted[15]}}, shifted[15:0]};
            instruction::LHU: load_result = {16'd0, shifted[15:0]};
            instruction::LW:  load_result = shifted;
            default:          load_result = pend_addr;
        endcase
    end

    // Stage FSM: accept, issue, wait for ack, optionally hold, then publish.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                        <= IDLE;
            rd_data_reg_out              <= '0;
            instruction_reg_out          <= instruction::NOP;
            program_counter_reg_out      <= constants::RESET_ADDRESS;
            next_program_counter_reg_out <= constants::RESET_ADDRESS;
            misaligned_reg_out           <= 1'b0;
            status_forwards_out          <= pipeline_status::BUBBLE;
            mem_cyc_out                  <= 1'b0;
            mem_stb_out                  <= 1'b0;
            mem_we_out                   <= 1'b0;
            mem_address_out              <= '0;
            mem_sel_out                  <= '0;
            mem_write_data_out           <= '0;
            pend_instr                   <= instruction::NOP;
            pend_pc                      <= constants::RESET_ADDRESS;
            pend_npc                     <= constants::RESET_ADDRESS;
            pend_addr                    <= '0;
            hold_data                    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && is_mem && !misaligned) begin
                        mem_cyc_out         <= 1'b1;
                        mem_stb_out         <= 1'b1;
                        mem_we_out          <= is_store;
                        mem_address_out     <= {rd_data_in[31:2], 2'b00};
                        mem_sel_out         <= sel;
                        mem_write_data_out  <= wdata;
                        pend_instr          <= instruction_in;
                        pend_pc             <= program_counter_in;
                        pend_npc            <= next_program_counter_in;
                        pend_addr           <= rd_data_in;
                        status_forwards_out <= pipeline_status::BUBBLE;
                        state               <= WAIT_ACK;
                    end else if (accept) begin
                        rd_data_reg_out              <= misaligned ? '0 : rd_data_in;
                        instruction_reg_out          <= instruction_in;
                        program_counter_reg_out      <= program_counter_in;
                        next_program_counter_reg_out <= next_program_counter_in;
                        misaligned_reg_out           <= misaligned;
                        status_forwards_out          <= pipeline_status::VALID;
                    end else if (!downstream_stall) begin
                        status_forwards_out <= pipeline_status::BUBBLE;
                    end
                end
                WAIT_ACK: begin
                    if (mem_ack_in) begin
                        mem_cyc_out        <= 1'b0;
                        mem_stb_out        <= 1'b0;
                        mem_we_out         <= 1'b0;
                        mem_address_out    <= '0;
                        mem_sel_out        <= '0;
                        mem_write_data_out <= '0;
                        if (!downstream_stall) begin
                            rd_data_reg_out              <= load_result;
                            instruction_reg_out          <= pend_instr;
                            program_counter_reg_out      <= pend_pc;
                            next_program_counter_reg_out <= pend_npc;
                            misaligned_reg_out           <= 1'b0;
                            status_forwards_out          <= pipeline_status::VALID;
                            state                        <= IDLE;
                        end else begin
                            hold_data <= load_result;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!downstream_stall) begin
                        rd_data_reg_out              <= hold_data;
                        instruction_reg_out          <= pend_instr;
                        program_counter_reg_out      <= pend_pc;
                        next_program_counter_reg_out <= pend_npc;
                        misaligned_reg_out           <= 1'b0;
                        status_forwards_out          <= pipeline_status::VALID;
                        state                        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
